mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Load/store unit between the pipeline's EX/MEM register and a word-wide data SRAM port with req/gnt/rvalid handshake.
//  Handles byte/half/word stores (lane replication + strobes) and loads (lane extract + sign/zero extend).
//  Raises stall_m to the hazard unit while an access is outstanding.
//  Load data feeds the MEM/WB register directly.
// PARAMETERS
//  TIMEOUT_CYCLES  255  watchdog limit on cycles waiting for gnt/rvalid (only with LSU_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock; all state on posedge
//  rst          in   1   asynchronous, active-low reset (0 = reset)
//  req_valid    in   1   M-stage access present; held stable by upstream while stall_m=1
//  req_write    in   1   1 = store, 0 = load
//  req_funct3   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr     in   32  byte address (alu_result_m)
//  req_wdata    in   32  store data (write_data_m), value in low bits
//  stall_m      out  1   hold F/D/E/M stages this cycle
//  load_data    out  32  extended load result; valid when load_valid=1
//  load_valid   out  1   load completes this cycle
//  misaligned   out  1   1-cycle pulse: misaligned address or illegal funct3; no memory access made
//  bus_error    out  1   1-cycle pulse: watchdog expiry (0 when LSU_TIMEOUT_EN undefined)
//  mem_req      out  1   request to SRAM
//  mem_we       out  1   write enable
//  mem_addr     out  32  word address, {req_addr[31:2],2'b00}
//  mem_wstrb    out  4   byte strobes
//  mem_wdata    out  32  lane-replicated store data
//  mem_gnt      in   1   request accepted this cycle
//  mem_rvalid   in   1   read data valid, >=1 cycle after gnt
//  mem_rdata    in   32  read data word
// BEHAVIOUR
//  Reset: state IDLE, captured regs 0, watchdog 0; all outputs 0 while req_valid=0.
//  FSM states: IDLE, WAIT_GNT, WAIT_RDATA.
//  - IDLE:
//      - Illegal req: misaligned=1, stall_m=0, stay IDLE.
//        Illegal = H with addr[0]=1, W with addr[1:0]!=0, funct3 not listed, or a store with BU/HU.
//      - Legal req: mem_* driven combinationally from inputs and request captured.
//        - gnt=0 -> WAIT_GNT, stall_m=1.
//        - gnt=1, store -> done, stall_m=0 (posted, single cycle).
//        - gnt=1, load -> WAIT_RDATA, stall_m=1.
//  - WAIT_GNT: mem_* driven from captured regs, stall_m=1.
//      - On gnt: store -> IDLE with stall_m=0 that cycle.
//      - On gnt: load -> WAIT_RDATA.
//  - WAIT_RDATA: mem_req=0, stall_m=1 until mem_rvalid.
//      - Rvalid cycle: load_valid=1, load_data=extend(mem_rdata), stall_m=0, -> IDLE.
//  Min latency: store 0 extra cycles; load 1 stall cycle (gnt in IDLE, rvalid next cycle).
//  Store lanes:
//      - B: wdata={4{d[7:0]}}, wstrb=1<<addr[1:0]
//      - H: wdata={2{d[15:0]}}, wstrb=addr[1]?1100:0011
//      - W: wstrb=1111
//  Load extract uses captured addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
//  Ignored inputs: mem_rvalid in IDLE/WAIT_GNT and mem_gnt outside IDLE/WAIT_GNT (stray, no effect).
//  Reset mid-access: immediate return to IDLE, mem_req drops asynchronously, late rvalid discarded.
//  One outstanding access max; the next req is accepted only in IDLE.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//      - An 8+ bit counter runs in WAIT_GNT/WAIT_RDATA and clears on state entry.
//      - On reaching TIMEOUT_CYCLES: bus_error=1 for 1 cycle, load_valid=1 with load_data=32'hdeadbeef for loads, stall_m=0, -> IDLE.
//  LSU_TIMEOUT_EN undefined: no counter; waits indefinitely; bus_error tied 0.
// STRUCTURE
//  lsu_pkg holds:
//      - mem_width_e funct3 enum (LSU_B/H/W/BU/HU)
//      - lsu_state_e
//      - DEADBEEF constant
//  Sub-module lsu_align (combinational) holds:
//      - store lane/strobe generation
//      - load extract/extend
//      - legality check
//  mem_stage_lsu keeps the FSM, capture regs and watchdog.
// TESTING
//  1 SW addr 0x100 d=0x11223344, gnt same cycle ->
//      mem_we=1, wstrb=1111, stall_m=0 entire access.
//  2 SB addr 0x103 d=0xAB, gnt after 2 cycles ->
//      wdata=0xABABABAB, wstrb=1000, stall_m=1 for 2 cycles.
//  3 LB addr 0x102, rdata=0x0080_0000, rvalid 1 cycle after gnt ->
//      load_data=0xFFFFFF80, load_valid=1, one stall cycle.
//      Then LBU on the same data -> 0x00000080.
//  4 LH addr 0x101 -> misaligned pulse, mem_req=0, stall_m=0.
//      LW addr 0x102 -> misaligned pulse.
//  5 Load granted, rst=0 before rvalid ->
//      IDLE, mem_req=0; rvalid after release ignored (load_valid=0).
//  6 (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4) load granted, no rvalid ->
//      bus_error=1 and load_data=0xDEADBEEF on 4th wait cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } mem_width_e;

  typedef logic [1:0] lsu_state_e;
  localparam lsu_state_e ST_IDLE       = 2'd0;
  localparam lsu_state_e ST_WAIT_GNT   = 2'd1;
  localparam lsu_state_e ST_WAIT_RDATA = 2'd2;

  localparam logic [31:0] DEADBEEF = 32'hdeadbeef;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/strobes, load extract/extend, legality.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] store_data,
  output logic [3:0]  store_strb,
  output logic [31:0] load_ext,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] shifted;

  assign shifted  = rdata >> {addr_lo, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Width decode; half accesses (signed or not) need an even address.
  always_comb begin
    store_data = wdata;
    store_strb = 4'b0000;
    load_ext   = rdata;
    illegal    = 1'b0;
    case (funct3)
      LSU_B: begin
        store_data = {4{wdata[7:0]}};
        store_strb = 4'b0001 << addr_lo;
        load_ext   = {{24{byte_sel[7]}}, byte_sel};
      end
      LSU_H: begin
        store_data = {2{wdata[15:0]}};
        store_strb = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_ext   = {{16{half_sel[15]}}, half_sel};
        illegal    = addr_lo[0];
      end
      LSU_W: begin
        store_strb = 4'b1111;
        illegal    = (addr_lo != 2'b00);
      end
      LSU_BU: begin
        load_ext = {24'h000000, byte_sel};
        illegal  = write;
      end
      LSU_HU: begin
        load_ext = {16'h0000, half_sel};
        illegal  = write | addr_lo[0];
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: FSM, request capture and SRAM handshake.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu
  import lsu_pkg::*;
  #(parameter int TIMEOUT_CYCLES = 255)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_m,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state, state_next;
  logic        cap_write;
  logic [2:0]  cap_funct3;
  logic [31:0] cap_addr, cap_wdata;
  logic        idle, cur_write, illegal, legal, timeout;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr, cur_wdata, store_data, load_ext;
  logic [3:0]  store_strb;

  assign idle       = (state == ST_IDLE);
  assign cur_write  = idle ? req_write  : cap_write;
  assign cur_funct3 = idle ? req_funct3 : cap_funct3;
  assign cur_addr   = idle ? req_addr   : cap_addr;
  assign cur_wdata  = idle ? req_wdata  : cap_wdata;
  assign legal      = rst & idle & req_valid & ~illegal;

  lsu_align u_align (
    .write      (cur_write),
    .funct3     (cur_funct3),
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .rdata      (mem_rdata),
    .store_data (store_data),
    .store_strb (store_strb),
    .load_ext   (load_ext),
    .illegal    (illegal)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wdog;

  assign timeout = rst & ~idle & (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on every state change, counts while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog <= '0;
    end else if (state_next != state) begin
      wdog <= '0;
    end else if (!idle) begin
      wdog <= wdog + WD_W'(1);
    end else begin
      wdog <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next state and handshake outputs; reset forces everything low at once.
  always_comb begin
    state_next = state;
    stall_m    = 1'b0;
    load_data  = 32'h00000000;
    load_valid = 1'b0;
    misaligned = 1'b0;
    bus_error  = 1'b0;
    mem_req    = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          misaligned = req_valid & illegal;
          if (legal) begin
            mem_req = 1'b1;
            if (mem_gnt) begin
              stall_m    = ~req_write;
              state_next = req_write ? ST_IDLE : ST_WAIT_RDATA;
            end else begin
              stall_m    = 1'b1;
              state_next = ST_WAIT_GNT;
            end
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_WAIT_GNT: begin
          mem_req = 1'b1;
          if (mem_gnt) begin
            stall_m    = ~cap_write;
            state_next = cap_write ? ST_IDLE : ST_WAIT_RDATA;
          end else if (timeout) begin
            bus_error  = 1'b1;
            load_valid = ~cap_write;
            load_data  = cap_write ? 32'h00000000 : DEADBEEF;
            state_next = ST_IDLE;
          end else begin
            stall_m = 1'b1;
          end
        end
        ST_WAIT_RDATA: begin
          if (mem_rvalid) begin
            load_valid = 1'b1;
            load_data  = load_ext;
            state_next = ST_IDLE;
          end else if (timeout) begin
            bus_error  = 1'b1;
            load_valid = 1'b1;
            load_data  = DEADBEEF;
            state_next = ST_IDLE;
          end else begin
            stall_m = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end else begin
      state_next = ST_IDLE;
    end
  end

  assign mem_we    = mem_req & cur_write;
  assign mem_addr  = mem_req ? {cur_addr[31:2], 2'b00} : 32'h00000000;
  assign mem_wstrb = mem_we ? store_strb : 4'b0000;
  assign mem_wdata = mem_we ? store_data : 32'h00000000;

  // State register and request capture for the wait states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cap_write  <= 1'b0;
      cap_funct3 <= 3'b000;
      cap_addr   <= 32'h00000000;
      cap_wdata  <= 32'h00000000;
    end else begin
      state <= state_next;
      if (legal) begin
        cap_write  <= req_write;
        cap_funct3 <= req_funct3;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
      end else begin
        cap_write  <= cap_write;
        cap_funct3 <= cap_funct3;
        cap_addr   <= cap_addr;
        cap_wdata  <= cap_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu; watchdog step only when LSU_TIMEOUT_EN is defined.
module tb_mem_stage_lsu;

`ifdef LSU_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk, rst;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall_m, load_valid, misaligned, bus_error;
  logic [31:0] load_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  int          total, passed;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_m(stall_m), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .bus_error(bus_error), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_stall", {31'd0, stall_m}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_load_valid", {31'd0, load_valid}, 32'd0);
    rst = 1'b1;
    tick();

    // 1: SW granted same cycle
    drive(1'b1, 3'b010, 32'h00000100, 32'h11223344); mem_gnt = 1'b1; #1;
    chk("sw_req", {31'd0, mem_req}, 32'd1);
    chk("sw_we", {31'd0, mem_we}, 32'd1);
    chk("sw_strb", {28'd0, mem_wstrb}, 32'h0000000f);
    chk("sw_wdata", mem_wdata, 32'h11223344);
    chk("sw_addr", mem_addr, 32'h00000100);
    chk("sw_stall", {31'd0, stall_m}, 32'd0);
    tick(); req_valid = 1'b0; mem_gnt = 1'b0; #1;
    chk("sw_after_req", {31'd0, mem_req}, 32'd0);

    // 2: SB at 0x103, grant after two cycles
    drive(1'b1, 3'b000, 32'h00000103, 32'h000000ab); #1;
    chk("sb_stall1", {31'd0, stall_m}, 32'd1);
    chk("sb_wdata", mem_wdata, 32'habababab);
    chk("sb_strb", {28'd0, mem_wstrb}, 32'h00000008);
    chk("sb_addr", mem_addr, 32'h00000100);
    tick();
    chk("sb_stall2", {31'd0, stall_m}, 32'd1);
    chk("sb_wait_req", {31'd0, mem_req}, 32'd1);
    tick(); mem_gnt = 1'b1; #1;
    chk("sb_gnt_stall", {31'd0, stall_m}, 32'd0);
    chk("sb_gnt_strb", {28'd0, mem_wstrb}, 32'h00000008);
    tick(); req_valid = 1'b0; mem_gnt = 1'b0; #1;
    chk("sb_done_req", {31'd0, mem_req}, 32'd0);

    // SH upper half
    drive(1'b1, 3'b001, 32'h00000102, 32'h00001234); mem_gnt = 1'b1; #1;
    chk("sh_wdata", mem_wdata, 32'h12341234);
    chk("sh_strb", {28'd0, mem_wstrb}, 32'h0000000c);
    tick(); req_valid = 1'b0; mem_gnt = 1'b0;

    // 3: LB then LBU at 0x102, rvalid one cycle after gnt
    drive(1'b0, 3'b000, 32'h00000102, 32'h0); mem_gnt = 1'b1; #1;
    chk("lb_stall", {31'd0, stall_m}, 32'd1);
    chk("lb_we", {31'd0, mem_we}, 32'd0);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00800000; #1;
    chk("lb_valid", {31'd0, load_valid}, 32'd1);
    chk("lb_data", load_data, 32'hffffff80);
    chk("lb_stall_end", {31'd0, stall_m}, 32'd0);
    chk("lb_rdata_req", {31'd0, mem_req}, 32'd0);
    tick(); mem_rvalid = 1'b0;
    drive(1'b0, 3'b100, 32'h00000102, 32'h0); mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
    chk("lbu_data", load_data, 32'h00000080);
    tick(); mem_rvalid = 1'b0;
    drive(1'b0, 3'b101, 32'h00000102, 32'h0); mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80010000; #1;
    chk("lhu_data", load_data, 32'h00008001);
    tick(); mem_rvalid = 1'b0; req_valid = 1'b0;

    // 4: illegal requests
    drive(1'b0, 3'b001, 32'h00000101, 32'h0); #1;
    chk("lh_mis", {31'd0, misaligned}, 32'd1);
    chk("lh_mis_req", {31'd0, mem_req}, 32'd0);
    chk("lh_mis_stall", {31'd0, stall_m}, 32'd0);
    tick();
    drive(1'b0, 3'b010, 32'h00000102, 32'h0); #1;
    chk("lw_mis", {31'd0, misaligned}, 32'd1);
    tick();
    drive(1'b1, 3'b100, 32'h00000100, 32'h0); #1;
    chk("sbu_illegal", {31'd0, misaligned}, 32'd1);
    tick(); req_valid = 1'b0; #1;
    chk("mis_clear", {31'd0, misaligned}, 32'd0);

    // 5: reset while waiting for rvalid
    drive(1'b0, 3'b010, 32'h00000200, 32'h0); mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; #1;
    chk("rm_wait_stall", {31'd0, stall_m}, 32'd1);
    rst = 1'b0; #1;
    chk("rm_req", {31'd0, mem_req}, 32'd0);
    chk("rm_stall", {31'd0, stall_m}, 32'd0);
    tick(); req_valid = 1'b0; rst = 1'b1;
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
    chk("rm_late_rvalid", {31'd0, load_valid}, 32'd0);
    tick(); mem_rvalid = 1'b0;

`ifdef LSU_TIMEOUT_EN
    // 6: granted load, rvalid never arrives
    drive(1'b0, 3'b010, 32'h00000300, 32'h0); mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; #1;
    chk("to_wait1", {31'd0, bus_error}, 32'd0);
    tick(); tick(); tick();
    chk("to_bus_error", {31'd0, bus_error}, 32'd1);
    chk("to_data", load_data, 32'hdeadbeef);
    chk("to_stall", {31'd0, stall_m}, 32'd0);
    tick(); req_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
